// File: rtl/aes_key_schedule.sv
// AES-128 key schedule: expands a cipher key into 11 round keys streamed over a valid/ready port,
// keeps the full schedule so it can be re-streamed on request without re-expansion.
module aes_key_schedule #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic         replay_valid,
  output logic         replay_ready,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         keys_stored
);

  if (NR != 10) begin : g_nr_check
    $fatal(1, "aes_key_schedule: only NR=10 (AES-128) is supported");
  end

  localparam int unsigned NumKeys = NR + 1;
  localparam logic [3:0]  LastIdx = 4'(NR);

  // FIPS-197 S-box, entry 0 in the MSBs.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StExpand, StStored, StReplay} state_e;

  state_e        state_q, state_d;
  logic [127:0]  rk_q, rk_d;
  logic [3:0]    idx_q, idx_d;
  logic          store_we;
  logic [127:0]  store_q [NumKeys];
  logic          key_hs, replay_hs, rk_hs, at_last;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SboxTable[{~a, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      rk_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
    end
  end

  // Storage is not reset; leaving STORED/REPLAY is what invalidates it.
  always_ff @(posedge clk) begin
    if (store_we) store_q[idx_q] <= rk_q;
  end

  assign key_hs    = key_valid && key_ready;
  assign replay_hs = replay_valid && replay_ready;
  assign rk_hs     = rk_valid && rk_ready;
  assign at_last   = (idx_q == LastIdx);

  always_comb begin
    state_d  = state_q;
    rk_d     = rk_q;
    idx_d    = idx_q;
    store_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (key_hs) begin
          state_d = StExpand;
          rk_d    = key_in;
          idx_d   = '0;
        end
      end
      StExpand: begin
        if (rk_hs) begin
          store_we = 1'b1;
          if (at_last) begin
            state_d = StStored;
          end else begin
            rk_d  = next_key(rk_q, rcon(idx_q + 4'd1));
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StStored: begin
        if (key_hs) begin
          state_d = StExpand;
          rk_d    = key_in;
          idx_d   = '0;
        end else if (replay_hs) begin
          state_d = StReplay;
          idx_d   = '0;
        end
      end
      StReplay: begin
        if (rk_hs) begin
          if (at_last) state_d = StStored;
          else         idx_d   = idx_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    key_ready    = 1'b0;
    replay_ready = 1'b0;
    rk_valid     = 1'b0;
    rk_data      = '0;
    keys_stored  = 1'b0;
    unique case (state_q)
      StIdle: key_ready = 1'b1;
      StExpand: begin
        rk_valid = 1'b1;
        rk_data  = rk_q;
      end
      StStored: begin
        key_ready    = 1'b1;
        // A coincident key wins, so the replay must not see a handshake.
        replay_ready = !key_valid;
        keys_stored  = 1'b1;
      end
      StReplay: begin
        rk_valid    = 1'b1;
        rk_data     = store_q[idx_q];
        keys_stored = 1'b1;
      end
      default: ;
    endcase
    rk_idx  = idx_q;
    rk_last = rk_valid && at_last;
  end

endmodule

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of cipher rounds; only 10 (AES-128) is legal, and any other value SHALL fail elaboration.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning reset, synchronous and active-low (0 = reset).
REQ-004 SHALL have port key_valid  input  1  meaning cipher key offered.
REQ-005 SHALL have port key_ready  output  1  meaning cipher key accepted this cycle if key_valid.
REQ-006 SHALL have port key_in  input  128  meaning cipher key; bits [127:96] = w0, first FIPS-197 byte in the MSBs.
REQ-007 SHALL have port replay_valid  input  1  meaning request to re-stream the stored schedule.
REQ-008 SHALL have port replay_ready  output  1  meaning replay request accepted this cycle if replay_valid.
REQ-009 SHALL have port rk_valid  output  1  meaning round key presented to the downstream AES round stage.
REQ-010 SHALL have port rk_ready  input  1  meaning downstream accepts the round key.
REQ-011 SHALL have port rk_data  output  128  meaning round key, same byte order as key_in.
REQ-012 SHALL have port rk_idx  output  4  meaning round index 0..10 of rk_data.
REQ-013 SHALL have port rk_last  output  1  meaning rk_valid && rk_idx == 10.
REQ-014 SHALL have port keys_stored  output  1  meaning a complete 11-key schedule is held internally.

Function
REQ-015 SHALL implement FSM states IDLE, EXPAND, STORED and REPLAY.
REQ-016 SHALL define a handshake as valid && ready high in the same cycle; no other condition SHALL advance state.
REQ-017 In IDLE, SHALL drive key_ready=1, replay_ready=0, rk_valid=0.
REQ-018 On a key handshake, SHALL register key_in as round key 0, set rk_idx=0 and enter EXPAND next cycle, so rk_valid rises one cycle after acceptance.
REQ-019 In EXPAND, SHALL drive rk_valid=1, key_ready=0, replay_ready=0.
REQ-020 On each rk handshake in EXPAND, SHALL write rk_data to storage slot rk_idx and load the next key computed combinationally with FIPS-197 KeyExpansion: RotWord, SubWord (combinational S-box, zero latency) and Rcon, then increment rk_idx.
REQ-021 SHALL sequence Rcon as 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10.
REQ-022 SHALL sustain throughput of one round key per cycle while rk_ready is held 1.
REQ-023 While rk_valid=1 and rk_ready=0, SHALL hold rk_data, rk_idx and rk_last stable.
REQ-024 On the rk handshake at rk_idx=10 in EXPAND, SHALL enter STORED and set keys_stored=1 the next cycle.
REQ-025 In STORED, SHALL drive rk_valid=0, key_ready=1, replay_ready=1.
REQ-026 In STORED, if key and replay handshakes coincide, SHALL let the key take priority: enter EXPAND and clear keys_stored, with the replay not accepted (replay_ready SHALL be 0 that cycle).
REQ-027 On a replay handshake in STORED, SHALL enter REPLAY with rk_idx=0.
REQ-028 In REPLAY, SHALL drive rk_data from storage slot rk_idx, with rk_valid=1 and key_ready=replay_ready=0.
REQ-029 In REPLAY, SHALL increment rk_idx on each rk handshake and return to STORED after the rk_idx=10 handshake.
REQ-030 SHALL ignore key_valid and replay_valid in any state where the corresponding ready is 0, with no side effect.
REQ-031 SHALL never advance rk_idx beyond 10; rk_idx does not wrap.
REQ-032 keys_stored SHALL be 1 in STORED and REPLAY and 0 in IDLE and EXPAND.

Reset
REQ-033 When rst=0 at a clock edge, SHALL enter IDLE and drive rk_valid=0, rk_data=0, rk_idx=0, rk_last=0, keys_stored=0, key_ready=1 and replay_ready=0 from the next cycle.
REQ-034 Reset asserted mid-EXPAND or mid-REPLAY SHALL abort the stream with no further rk_valid, and SHALL invalidate the stored schedule; storage contents need not be cleared.
REQ-035 SHALL accept a key in the first cycle after rst returns to 1.

Verification
REQ-036 Reset then key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1 -> rk_valid high for exactly 11 consecutive cycles starting one cycle after acceptance; idx1 = a0fafe1788542cb123a339392a6c7605, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1, then keys_stored=1.
REQ-037 Same key with rk_ready toggling 1,0,0,1 repeatedly -> identical 11 keys in order; rk_data and rk_idx unchanged during every stalled cycle.
REQ-038 After REQ-036, replay_valid pulse -> same 11 keys re-streamed in order, no key handshake required.
REQ-039 In STORED, key_valid and replay_valid asserted together with key 000102030405060708090a0b0c0d0e0f -> key accepted, replay ignored; idx10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-040 rst=0 asserted at rk_idx=4 during EXPAND -> next cycle rk_valid=0, rk_idx=0, keys_stored=0, key_ready=1; a replay_valid pulse afterwards is not accepted.
REQ-041 key_valid pulsed during EXPAND and REPLAY -> key not accepted and stream unaffected.
